// File: rtl/en_hold_filter_if.sv
// Signal bundle for en_hold_filter: enable/data/clear inputs, filtered data,
// tracking flag, event counters and a state debug tap.
interface en_hold_filter_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
);
  // Plain level interface with no valid/ready pair. Every input is sampled on
  // each rising clk edge, and every output is a flop that changes only on that edge.
  logic             en;
  logic [WIDTH-1:0] bar;
  logic             clr;
  logic [WIDTH-1:0] foo;
  logic             tracking;
  logic [CNT_W-1:0] chg_cnt;
  logic [CNT_W-1:0] drop_cnt;
  logic [1:0]       dbg_state;

  modport master (
    output en, bar, clr,
    input  foo, tracking, chg_cnt, drop_cnt, dbg_state
  );

  modport slave (
    input  en, bar, clr,
    output foo, tracking, chg_cnt, drop_cnt, dbg_state
  );
endinterface

// File: rtl/en_hold_filter.sv
// Enable-qualified data register. foo follows bar only after en has been high
// for FILT consecutive samples. Saturating counters record updates and stale-hold changes.
module en_hold_filter #(
  parameter int WIDTH = 1,
  parameter int FILT  = 2,
  parameter int CNT_W = 8
) (
  input logic            clk,
  input logic            rst_n,
  en_hold_filter_if.slave bus
);

  localparam int QW = (FILT > 1) ? $clog2(FILT) : 1;
  localparam logic [QW-1:0] QLAST = QW'(FILT - 1);

  // Encoding is visible on dbg_state: 0 idle, 1 qualifying, 2 tracking
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_QUAL  = 2'd1,
    S_TRACK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [QW-1:0]    qcnt_q, qcnt_d;
  logic [WIDTH-1:0] foo_q, foo_d;
  logic [WIDTH-1:0] bar_q, bar_d;
  logic             tracking_q, tracking_d;
  logic [CNT_W-1:0] chg_q, chg_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             upd;
  logic             chg_inc;
  logic             drop_inc;

  always_comb begin
    state_d = state_q;
    qcnt_d  = qcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.en) begin
          if (FILT == 1) begin
            state_d = S_TRACK;
          end else begin
            state_d = S_QUAL;
            qcnt_d  = QW'(1);
          end
        end
      end
      S_QUAL: begin
        if (!bus.en) begin
          state_d = S_IDLE;
          qcnt_d  = '0;
        end else if (qcnt_q == QLAST) begin
          state_d = S_TRACK;
          qcnt_d  = '0;
        end else begin
          qcnt_d = qcnt_q + QW'(1);
        end
      end
      S_TRACK: begin
        if (!bus.en) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        qcnt_d  = '0;
      end
    endcase
  end

  // foo only loads while already tracking; the edge that drops en leaves it held
  always_comb begin
    upd        = (state_q == S_TRACK) && bus.en;
    foo_d      = upd ? bus.bar : foo_q;
    bar_d      = bus.bar;
    tracking_d = (state_d == S_TRACK);
    chg_inc    = upd && (bus.bar != foo_q);
    drop_inc   = (state_q != S_TRACK) && (bus.bar != bar_q);

    chg_d = chg_q;
    if (bus.clr) chg_d = '0;
    else if (chg_inc && (chg_q != {CNT_W{1'b1}})) chg_d = chg_q + CNT_W'(1);

    drop_d = drop_q;
    if (bus.clr) drop_d = '0;
    else if (drop_inc && (drop_q != {CNT_W{1'b1}})) drop_d = drop_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      qcnt_q     <= '0;
      foo_q      <= '0;
      bar_q      <= '0;
      tracking_q <= 1'b0;
      chg_q      <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      qcnt_q     <= qcnt_d;
      foo_q      <= foo_d;
      bar_q      <= bar_d;
      tracking_q <= tracking_d;
      chg_q      <= chg_d;
      drop_q     <= drop_d;
    end
  end

  assign bus.foo       = foo_q;
  assign bus.tracking  = tracking_q;
  assign bus.chg_cnt   = chg_q;
  assign bus.drop_cnt  = drop_q;
  assign bus.dbg_state = state_q;

  a_follow: assert property (@(posedge clk) disable iff (!rst_n)
    (tracking_q && $past(tracking_q) && $past(bus.en)) |-> (foo_q == $past(bus.bar)));

  a_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (!$past(tracking_q)) |-> (foo_q == $past(foo_q)));

  c_diff: cover property (@(posedge clk) disable iff (!rst_n)
    tracking_q && (bus.bar != foo_q));

endmodule

// File: tb/tb_en_hold_filter.sv
// Directed bench for en_hold_filter. Three instances (FILT=2/CNT_W=8, FILT=2/CNT_W=2,
// FILT=1/CNT_W=8) share one stimulus stream, and each is checked against hand-computed values.
module tb_en_hold_filter;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic bar;
  logic clr;

  int n_total = 0;
  int n_bad   = 0;
  int qual_a  = 0;
  int qual_c  = 0;

  en_hold_filter_if #(.WIDTH(1), .CNT_W(8)) if_a ();
  en_hold_filter_if #(.WIDTH(1), .CNT_W(2)) if_b ();
  en_hold_filter_if #(.WIDTH(1), .CNT_W(8)) if_c ();

  assign if_a.en = en;  assign if_a.bar = bar;  assign if_a.clr = clr;
  assign if_b.en = en;  assign if_b.bar = bar;  assign if_b.clr = clr;
  assign if_c.en = en;  assign if_c.bar = bar;  assign if_c.clr = clr;

  en_hold_filter #(.WIDTH(1), .FILT(2), .CNT_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  en_hold_filter #(.WIDTH(1), .FILT(2), .CNT_W(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
  en_hold_filter #(.WIDTH(1), .FILT(1), .CNT_W(8)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && if_a.dbg_state == 2'd1) qual_a++;
    if (rst_n && if_c.dbg_state == 2'd1) qual_c++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    bar   = 1'b0;
    clr   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    bar   = 1'b0;
    clr   = 1'b0;
    tick();
    check("rst_foo",  32'(if_a.foo), 0);
    check("rst_trk",  32'(if_a.tracking), 0);
    check("rst_chg",  32'(if_a.chg_cnt), 0);
    check("rst_drop", 32'(if_a.drop_cnt), 0);
    tick();
    rst_n = 1'b1;

    // basic qualification, FILT=2 on a, FILT=1 on c
    en = 1'b1; bar = 1'b1;
    tick();
    check("s1_trk_e0",   32'(if_a.tracking), 0);
    check("s5_c_trk_e0", 32'(if_c.tracking), 1);
    check("s5_c_foo_e0", 32'(if_c.foo), 0);
    tick();
    check("s1_trk_e1",   32'(if_a.tracking), 1);
    check("s1_foo_e1",   32'(if_a.foo), 0);
    check("s5_c_foo_e1", 32'(if_c.foo), 1);
    tick();
    check("s1_foo_e2", 32'(if_a.foo), 1);
    check("s1_chg_e2", 32'(if_a.chg_cnt), 1);
    tick();
    check("s1_chg_e3",  32'(if_a.chg_cnt), 1);
    check("s1_drop_e3", 32'(if_a.drop_cnt), 1);

    // drop en while tracking, with clr on the same edge
    en = 1'b0; clr = 1'b1;
    tick();
    check("s3_trk_n",  32'(if_a.tracking), 0);
    check("s3_foo_n",  32'(if_a.foo), 1);
    check("s3_drop_n", 32'(if_a.drop_cnt), 0);
    check("s3_chg_n",  32'(if_a.chg_cnt), 0);
    clr = 1'b0;
    bar = 1'b0; tick();
    bar = 1'b1; tick();
    bar = 1'b0; tick();
    check("s3_drop_n3", 32'(if_a.drop_cnt), 3);
    check("s3_foo_n3",  32'(if_a.foo), 1);
    check("s3_trk_n3",  32'(if_a.tracking), 0);

    // one-cycle en pulse then toggling bar
    do_reset();
    en = 1'b1; bar = 1'b0;
    tick();
    check("s2_trk_e0", 32'(if_a.tracking), 0);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bar = ~bar;
      tick();
      check("s2_trk", 32'(if_a.tracking), 0);
    end
    check("s2_drop", 32'(if_a.drop_cnt), 4);
    check("s2_foo",  32'(if_a.foo), 0);

    // saturation on the 2-bit counter, then clr on a change edge
    do_reset();
    en = 1'b1; bar = 1'b1;
    tick(); tick(); tick();
    check("s4_b_foo",  32'(if_b.foo), 1);
    check("s4_b_chg0", 32'(if_b.chg_cnt), 1);
    check("s4_b_drop", 32'(if_b.drop_cnt), 1);
    for (int i = 0; i < 5; i++) begin
      bar = ~bar;
      tick();
    end
    check("s4_b_chg_sat", 32'(if_b.chg_cnt), 3);
    check("s4_a_chg",     32'(if_a.chg_cnt), 6);
    check("s4_b_foo5",    32'(if_b.foo), 0);
    bar = 1'b1; clr = 1'b1;
    tick();
    check("s4_b_chg_clr",  32'(if_b.chg_cnt), 0);
    check("s4_a_chg_clr",  32'(if_a.chg_cnt), 0);
    check("s4_b_drop_clr", 32'(if_b.drop_cnt), 0);
    check("s4_b_foo_clr",  32'(if_b.foo), 1);
    clr = 1'b0; bar = 1'b0;
    tick();
    check("s4_b_chg_after", 32'(if_b.chg_cnt), 1);

    // asynchronous reset while tracking, then requalification
    do_reset();
    en = 1'b1; bar = 1'b1;
    tick(); tick(); tick();
    check("s6_foo_pre", 32'(if_a.foo), 1);
    check("s6_trk_pre", 32'(if_a.tracking), 1);
    #3 rst_n = 1'b0;
    #1;
    check("s6_foo_rst",   32'(if_a.foo), 0);
    check("s6_trk_rst",   32'(if_a.tracking), 0);
    check("s6_chg_rst",   32'(if_a.chg_cnt), 0);
    check("s6_c_trk_rst", 32'(if_c.tracking), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("s6_trk_e0",   32'(if_a.tracking), 0);
    check("s6_c_trk_e0", 32'(if_c.tracking), 1);
    tick();
    check("s6_trk_e1", 32'(if_a.tracking), 1);
    check("s6_foo_e1", 32'(if_a.foo), 0);
    tick();
    check("s6_foo_e2", 32'(if_a.foo), 1);

    check("c_no_qual",  32'(qual_c), 0);
    check("a_qual_hit", 32'(qual_a > 0), 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
